// File: rtl/replay_buffer_mux.sv
// Transmit side of the column time-multiplexer: captures one gamma cycle of two-network spikes
// per lane into a ping-pong bank, then replays it downsampled x2 on one wire per lane.
module replay_buffer_mux #(
  parameter int unsigned Q                  = 2,
  parameter int unsigned GAMMA_CYCLE_LENGTH = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_gamma_start,
  input  logic [Q-1:0][1:0]    i_in_spikes,
  output logic [Q-1:0]         o_mux_out,
  output logic                 o_net_sel,
  output logic                 o_frame_valid,
  output logic                 o_sync_err
);

  localparam int unsigned G  = GAMMA_CYCLE_LENGTH;
  localparam int unsigned H  = G / 2;
  localparam int unsigned CW = $clog2(G);

  if ((GAMMA_CYCLE_LENGTH % 2) != 0 || GAMMA_CYCLE_LENGTH < 4) begin : g_bad_len
    $error("replay_buffer_mux: GAMMA_CYCLE_LENGTH must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_t;

  state_t          r_state;
  state_t          w_state_d;
  logic [CW-1:0]   r_cnt;
  logic            r_wr_bank;
  logic [G-1:0]    r_bank [2][Q][2];

  logic            w_active;
  logic            w_last;
  logic            w_wrap;
  logic [CW-1:0]   w_phase;
  logic            w_wb;
  logic            w_rb;
  logic            w_net;
  logic [CW-1:0]   w_idx;
  logic [CW-1:0]   w_base;
  logic [CW-1:0]   w_base1;
  logic [Q-1:0]    w_mux;

  always_comb begin
    // The start pulse seen in IDLE is itself phase 0 of the first captured cycle.
    w_active = i_en && ((r_state != StIdle) || i_gamma_start);
    w_last   = (r_cnt == CW'(G - 1));
    w_wrap   = w_active && (i_gamma_start || w_last);
    w_phase  = (i_gamma_start || w_last) ? '0 : r_cnt + CW'(1);
    w_wb     = w_wrap ? ~r_wr_bank : r_wr_bank;
    w_rb     = ~w_wb;

    w_state_d = r_state;
    if (!i_en) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (i_gamma_start) w_state_d = StFill;
        StFill:   if (w_wrap)        w_state_d = StStream;
        StStream: w_state_d = StStream;
        default:  w_state_d = StIdle;
      endcase
    end

    w_net   = (w_phase >= CW'(H));
    w_idx   = w_net ? (w_phase - CW'(H)) : w_phase;
    w_base  = w_idx << 1;
    w_base1 = w_base + CW'(1);
    w_mux   = '0;
    for (int q = 0; q < Q; q++) begin
      w_mux[q] = r_bank[w_rb][q][w_net][w_base] | r_bank[w_rb][q][w_net][w_base1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_wr_bank     <= 1'b0;
      o_mux_out     <= '0;
      o_net_sel     <= 1'b0;
      o_frame_valid <= 1'b0;
      o_sync_err    <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int q = 0; q < Q; q++)
          for (int n = 0; n < 2; n++)
            r_bank[b][q][n] <= '0;
    end else begin
      r_state <= w_state_d;

      if (!i_en) begin
        r_cnt     <= '0;
        r_wr_bank <= 1'b0;
        for (int b = 0; b < 2; b++)
          for (int q = 0; q < Q; q++)
            for (int n = 0; n < 2; n++)
              r_bank[b][q][n] <= '0;
      end else if (w_active) begin
        r_cnt <= w_phase;
        if (w_wrap) r_wr_bank <= ~r_wr_bank;
        for (int q = 0; q < Q; q++) begin
          for (int n = 0; n < 2; n++) begin
            // Clearing on wrap keeps a truncated cycle from replaying stale tail bits.
            if (w_wrap) r_bank[w_wb][q][n] <= {{(G-1){1'b0}}, i_in_spikes[q][n]};
            else        r_bank[w_wb][q][n][w_phase] <= i_in_spikes[q][n];
          end
        end
        if (r_state != StIdle && (i_gamma_start ? !w_last : w_last)) o_sync_err <= 1'b1;
      end

      if (w_state_d == StStream) begin
        o_mux_out     <= w_mux;
        o_net_sel     <= w_net;
        o_frame_valid <= 1'b1;
      end else begin
        o_mux_out     <= '0;
        o_net_sel     <= 1'b0;
        o_frame_valid <= 1'b0;
      end
    end
  end

endmodule
